// File: rtl/polyphase_pkg.sv
// Shared definitions for the polyphase filter family: loader FSM states and
// the tap-address width helper used by both the loader and the filter.
package polyphase_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } fsm_state_t;

  // Degenerate single-tap banks still need a one-bit address.
  function automatic int tap_addr_w(input int number_taps);
    return (number_taps > 1) ? $clog2(number_taps) : 1;
  endfunction

endpackage

// File: rtl/polyphase_coeff_loader_if.sv
// AXI-Stream coefficient channel from the loader to the polyphase filter.
interface polyphase_coeff_loader_if #(
  parameter int COEFFICIENT_WIDTH = 16
) ();

  logic signed [COEFFICIENT_WIDTH-1:0] tdata;
  logic                                tvalid;
  logic                                tlast;
  logic                                tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/polyphase_coeff_loader_tap_ram.sv
// Tap storage: simple dual-port RAM, one write port, one synchronous read
// port, no reset so contents survive a block reset.
module coeff_tap_ram #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [WIDTH-1:0]  rd_data
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/polyphase_coeff_loader.sv
// Holds one prototype tap set and, on request, resets the downstream filter
// and streams the taps over AXI-Stream, one transfer per tap.
module polyphase_coeff_loader
  import polyphase_pkg::*;
#(
  parameter int NUMBER_TAPS       = 32,
  parameter int COEFFICIENT_WIDTH = 16,
  parameter int RESET_CYCLES      = 4,
  parameter bit REVERSE_ORDER     = 1'b0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                cfg_wr_en,
  input  logic [$clog2(NUMBER_TAPS)-1:0]      cfg_wr_addr,
  input  logic signed [COEFFICIENT_WIDTH-1:0] cfg_wr_data,
  input  logic                                load_start,
  output logic                                filter_reset,
  polyphase_coeff_loader_if.master            coefficients_out,
  output logic                                busy,
  output logic                                load_done,
  output logic                                cfg_error
);

  localparam int ADDR_W  = tap_addr_w(NUMBER_TAPS);
  localparam int FLUSH_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [ADDR_W-1:0]  FIRST_IDX  = REVERSE_ORDER ? ADDR_W'(NUMBER_TAPS-1) : '0;
  localparam logic [ADDR_W-1:0]  LAST_IDX   = REVERSE_ORDER ? '0 : ADDR_W'(NUMBER_TAPS-1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(RESET_CYCLES-1);

  function automatic logic [ADDR_W-1:0] step_idx(input logic [ADDR_W-1:0] idx);
    if (REVERSE_ORDER) begin
      return (idx == '0) ? ADDR_W'(NUMBER_TAPS-1) : idx - 1'b1;
    end
    return (idx == ADDR_W'(NUMBER_TAPS-1)) ? '0 : idx + 1'b1;
  endfunction

  fsm_state_t                     state_q, state_d;
  logic [FLUSH_W-1:0]             flush_cnt;
  logic [ADDR_W-1:0]              tap_idx;
  logic [ADDR_W-1:0]              rd_addr;
  logic signed [COEFFICIENT_WIDTH-1:0] rd_data_p0;
  logic signed [COEFFICIENT_WIDTH-1:0] fwd_data_p0;
  logic                           fwd_vld_p0;
  logic signed [COEFFICIENT_WIDTH-1:0] tdata_p1;
  logic                           vld_p1;
  logic                           tlast_p1;

  logic busy_state, start_ok, wr_addr_ok, wr_ok, hs, flush_done;

  assign busy_state = (state_q == FLUSH) || (state_q == STREAM);
  assign start_ok   = load_start && !busy_state;
  assign wr_addr_ok = int'(cfg_wr_addr) < NUMBER_TAPS;
  assign wr_ok      = cfg_wr_en && !busy_state && wr_addr_ok;
  assign hs         = vld_p1 && coefficients_out.tready;
  assign flush_done = (state_q == FLUSH) && (flush_cnt == FLUSH_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = FLUSH;
      FLUSH:   if (flush_cnt == FLUSH_LAST) state_d = STREAM;
      STREAM:  if (hs && tlast_p1) state_d = DONE;
      DONE:    state_d = load_start ? FLUSH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read address runs one tap ahead of the output register; on a handshake
  // it jumps two ahead so the prefetch is ready for the following beat.
  always_comb begin
    rd_addr = FIRST_IDX;
    case (state_q)
      FLUSH:   if (flush_done) rd_addr = step_idx(FIRST_IDX);
      STREAM:  rd_addr = hs ? step_idx(step_idx(tap_idx)) : step_idx(tap_idx);
      default: rd_addr = FIRST_IDX;
    endcase
  end

  // Stage p0: tap RAM read (the prefetch register)
  coeff_tap_ram #(
    .DEPTH  (NUMBER_TAPS),
    .WIDTH  (COEFFICIENT_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_tap_ram (
    .clock   (clock),
    .wr_en   (wr_ok),
    .wr_addr (cfg_wr_addr),
    .wr_data (cfg_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data_p0)
  );

  // A write to the first tap in the load_start cycle is missed by the RAM read
  // when RESET_CYCLES is 1, so it is captured here and forwarded.
  always_ff @(posedge clock) begin
    if (start_ok) begin
      fwd_data_p0 <= cfg_wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      flush_cnt    <= '0;
      tap_idx      <= '0;
      fwd_vld_p0   <= 1'b0;
      vld_p1       <= 1'b0;
      tlast_p1     <= 1'b0;
      tdata_p1     <= '0;
      filter_reset <= 1'b0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt    <= (state_q == FLUSH) ? flush_cnt + 1'b1 : '0;
      filter_reset <= (state_d == FLUSH);
      busy         <= (state_d == FLUSH) || (state_d == STREAM);
      load_done    <= (state_d == DONE);
      cfg_error    <= cfg_error
                      | (load_start && busy_state)
                      | (cfg_wr_en && (busy_state || !wr_addr_ok));
      if (start_ok) begin
        fwd_vld_p0 <= wr_ok && (cfg_wr_addr == FIRST_IDX);
      end
      // Stage p1: registered AXI-Stream output
      if (flush_done) begin
        vld_p1   <= 1'b1;
        tlast_p1 <= 1'b0;
        tdata_p1 <= fwd_vld_p0 ? fwd_data_p0 : rd_data_p0;
        tap_idx  <= FIRST_IDX;
      end else if (hs) begin
        if (tlast_p1) begin
          vld_p1   <= 1'b0;
          tlast_p1 <= 1'b0;
        end else begin
          tdata_p1 <= rd_data_p0;
          tap_idx  <= step_idx(tap_idx);
          tlast_p1 <= (step_idx(tap_idx) == LAST_IDX);
        end
      end
    end
  end

  assign coefficients_out.tdata  = tdata_p1;
  assign coefficients_out.tvalid = vld_p1;
  assign coefficients_out.tlast  = tlast_p1;

endmodule
